mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the single 512x16 synchronous data/instruction RAM. It shares the RAM between the CPU memory port and a DMA/debug-loader port and serialises their accesses. Each port makes one access at a time using a command/acknowledge handshake. All outputs are registered. The block sits between the `cpu` instance, the loader and the RAM macro in the top level.

## Interface
Parameters:
- AW, 9, address width (RAM depth 2^AW words)
- DW, 16, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_cmd  in  2  CPU command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 treated as NONE
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  last CPU read data, held until the next CPU read completes
- cpu_ack  out  1  one-cycle pulse: CPU transaction complete
- dma_cmd  in  2  DMA command, same encoding as cpu_cmd
- dma_addr  in  AW  DMA word address
- dma_wdata  in  DW  DMA write data
- dma_rdata  out  DW  last DMA read data, held
- dma_ack  out  1  one-cycle pulse: DMA transaction complete
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after the address is sampled
- busy  out  1  high whenever state is not IDLE
- owner  out  1  current/last grant: 0 CPU, 1 DMA

## Operation
- States:
  - IDLE: samples both cmds. If any is valid, latches the winner's op, addr and wdata into internal registers, sets owner, and moves to ACCESS.
  - ACCESS: drives ram_addr and ram_wdata from the latched values; ram_we=1 only for WRITE.
    - READ goes to WAIT.
    - WRITE goes to RESP.
  - WAIT: ram_rdata is valid; it is registered into the owner's rdata at the end of the cycle. Goes to RESP.
  - RESP: owner's ack=1 for exactly this cycle. Goes to IDLE.
- Arbitration happens only in IDLE. If only one port requests, that port wins.
- If both ports request, the winner is CPU by default (see Configuration).
- Requests arriving while busy are not sampled. They are serviced at the next IDLE if still asserted.
- Requesters hold cmd/addr/wdata until ack. They must deassert cmd or present the next request in the cycle after ack.
- After latching, cmd/addr/wdata are don't-care. If a requester drops cmd mid-transaction, the transaction still completes and the ack is still issued.
- The non-owner's rdata and ack are unchanged during any transaction.
- Address is word-granular with no wrap logic. ram_addr equals the latched AW bits exactly, so address 2^AW-1 is valid.

## Timing
- Reset values:
  - state IDLE
  - cpu_ack=0, dma_ack=0, ram_we=0
  - ram_addr=0, ram_wdata=0
  - cpu_rdata=0, dma_rdata=0
  - busy=0, owner=0
  - rr_last=1
- Read: cmd valid in cycle 0 (IDLE). ACCESS in cycle 1, WAIT in cycle 2, RESP in cycle 3. rdata is valid from cycle 3 (with ack) onward.
- Write: cmd valid in cycle 0. ACCESS in cycle 1 with ram_we=1. RESP (ack) in cycle 2. RAM contents are updated at the end of cycle 1.
- Throughput: one read per 4 cycles, one write per 3 cycles. The mandatory IDLE cycle after RESP is the arbitration slot.
- ram_we is high only in ACCESS for a WRITE. It is never high in IDLE, WAIT or RESP.
- Reset mid-operation aborts the transaction:
  - no ack is issued
  - ram_we is low from the reset edge onward
  - a partially completed read does not update rdata
- cpu_ack and dma_ack are never high in the same cycle.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration. Register rr_last records the last granted port.
  - On a simultaneous request, the port other than rr_last wins; rr_last updates on every grant.
  - rr_last resets to 1, so CPU wins the first tie.
- MEM_ARB_RR_EN undefined:
  - Fixed priority: CPU always wins ties.
  - rr_last is not implemented. A continuously requesting CPU starves DMA, and this is accepted behaviour.

## Test plan
- Reset, then idle: all outputs at reset values; ram_we=0 for 10 cycles with both cmds NONE.
- CPU WRITE addr 9'h1A data 16'hBEEF, then CPU READ 9'h1A:
  - cpu_ack in cycle 2 for the write.
  - cpu_ack in cycle 3 for the read, with cpu_rdata=16'hBEEF.
  - dma_ack stays 0.
- Both READ in the same cycle (CPU addr 9'h000, DMA addr 9'h1FF), both held:
  - Fixed priority: CPU acks first; DMA acks 4 cycles later.
  - With MEM_ARB_RR_EN, a second tie after that goes to the port not granted last.
- DMA WRITE 9'h1FF = 16'h1234 while the CPU asserts READ 9'h1FF during ACCESS: the CPU is served after the DMA ack and reads 16'h1234.
- Reset asserted during WAIT of a CPU read: no cpu_ack, cpu_rdata=0, state IDLE after the edge.
- Command 2'b11 on both ports for 5 cycles: busy stays 0 and ram_we stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU port, the DMA/loader port, the RAM macro and mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic [1:0]    dma_cmd;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_cmd, cpu_addr, cpu_wdata, dma_cmd, dma_addr, dma_wdata, ram_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_cmd, cpu_addr, cpu_wdata, dma_cmd, dma_addr, dma_wdata, ram_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed CPU priority.
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic          op_write;
  logic          cpu_req, dma_req;
  logic          tie_dma;
  logic          grant_dma;
  logic [1:0]    win_cmd;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef MEM_ARB_RR_EN
  logic rr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (state == IDLE && state_next == ACCESS) begin
      rr_last <= grant_dma;
    end
  end

  // On a tie the port that was not granted last wins.
  assign tie_dma = ~rr_last;
`else
  assign tie_dma = 1'b0;
`endif

  always_comb begin
    cpu_req    = (bus.cpu_cmd == CMD_READ) || (bus.cpu_cmd == CMD_WRITE);
    dma_req    = (bus.dma_cmd == CMD_READ) || (bus.dma_cmd == CMD_WRITE);
    grant_dma  = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_next = ACCESS;
          grant_dma  = dma_req && (!cpu_req || tie_dma);
        end
      end
      ACCESS:  state_next = op_write ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    win_cmd   = grant_dma ? bus.dma_cmd   : bus.cpu_cmd;
    win_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
    win_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  // ram_addr/ram_wdata double as the latched request; they hold until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_write      <= 1'b0;
      owner         <= 1'b0;
      busy          <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_we    <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      bus.ram_we  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;

      if (state == IDLE && state_next == ACCESS) begin
        owner         <= grant_dma;
        op_write      <= (win_cmd == CMD_WRITE);
        bus.ram_addr  <= win_addr;
        bus.ram_wdata <= win_wdata;
        bus.ram_we    <= (win_cmd == CMD_WRITE);
      end

      if (state == WAIT) begin
        if (owner) bus.dma_rdata <= bus.ram_rdata;
        else       bus.cpu_rdata <= bus.ram_rdata;
      end

      if (state_next == RESP) begin
        bus.cpu_ack <= ~owner;
        bus.dma_ack <= owner;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks,
// an independent negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;

  logic clk = 1'b0;
  logic reset;
  logic busy, owner;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   last_grant = 1'b1;
  logic [15:0] last_cpu_rdata = 16'h0;
  logic [15:0] last_dma_rdata = 16'h0;
  logic [15:0] mem [512];

  typedef struct {
    bit          port;
    bit          is_read;
    logic [15:0] rdata;
    int          at;
  } exp_t;
  exp_t q[$];

  mem_arbiter_if #(.AW(9), .DW(16)) bus();

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic expect_ack(input bit port, input bit is_read, input logic [15:0] rd, input int at);
    exp_t e;
    e.port = port; e.is_read = is_read; e.rdata = rd; e.at = at;
    q.push_back(e);
    last_grant = port;
  endtask

  task automatic drive(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wdata);
    int  n;
    bit  seen;
    if (port) begin
      bus.dma_cmd = cmd; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_cmd = cmd; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = port ? bus.dma_ack : bus.cpu_ack;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout port=%0d: got no ack expected ack within 20 cycles", port);
    end
    @(posedge clk); #1;
    if (port) bus.dma_cmd = NONE;
    else      bus.cpu_cmd = NONE;
  endtask

  task automatic tie(input logic [8:0] caddr, input logic [15:0] cexp,
                     input logic [8:0] daddr, input logic [15:0] dexp);
    int c;
    bit w;
    c = cyc;
`ifdef MEM_ARB_RR_EN
    w = (last_grant == 1'b1) ? 1'b0 : 1'b1;
`else
    w = 1'b0;
`endif
    if (w == 1'b0) begin
      expect_ack(1'b0, 1'b1, cexp, c + 3);
      expect_ack(1'b1, 1'b1, dexp, c + 7);
    end else begin
      expect_ack(1'b1, 1'b1, dexp, c + 3);
      expect_ack(1'b0, 1'b1, cexp, c + 7);
    end
    fork
      drive(1'b0, READ, caddr, 16'h0);
      drive(1'b1, READ, daddr, 16'h0);
    join
  endtask

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   port;
    if (!reset) begin
      if (bus.cpu_ack && bus.dma_ack) begin
        checks++; errors++;
        $display("FAIL both_ack: got cpu_ack=1 dma_ack=1 expected at most one");
      end else if (bus.cpu_ack || bus.dma_ack) begin
        port = bus.dma_ack;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack on port %0d expected none", port);
        end else begin
          e = q.pop_front();
          check("ack_port", int'(port), int'(e.port));
          check("ack_cycle", cyc, e.at);
          check("ack_owner", int'(owner), int'(e.port));
          if (port) begin
            if (e.is_read) begin
              check("dma_rdata", int'(bus.dma_rdata), int'(e.rdata));
              last_dma_rdata = e.rdata;
            end
            check("cpu_rdata_held", int'(bus.cpu_rdata), int'(last_cpu_rdata));
          end else begin
            if (e.is_read) begin
              check("cpu_rdata", int'(bus.cpu_rdata), int'(e.rdata));
              last_cpu_rdata = e.rdata;
            end
            check("dma_rdata_held", int'(bus.dma_rdata), int'(last_dma_rdata));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    bus.cpu_cmd = NONE; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_cmd = NONE; bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack",   int'(bus.cpu_ack),   0);
    check("rst_dma_ack",   int'(bus.dma_ack),   0);
    check("rst_ram_we",    int'(bus.ram_we),    0);
    check("rst_ram_addr",  int'(bus.ram_addr),  0);
    check("rst_ram_wdata", int'(bus.ram_wdata), 0);
    check("rst_cpu_rdata", int'(bus.cpu_rdata), 0);
    check("rst_dma_rdata", int'(bus.dma_rdata), 0);
    check("rst_busy",      int'(busy),          0);
    check("rst_owner",     int'(owner),         0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_ram_we", int'(bus.ram_we), 0);
      check("idle_busy",   int'(busy),       0);
    end
    @(posedge clk); #1;

    // CPU write then read back
    c = cyc; expect_ack(1'b0, 1'b0, 16'h0, c + 2);
    drive(1'b0, WRITE, 9'h01A, 16'hBEEF);
    c = cyc; expect_ack(1'b0, 1'b1, 16'hBEEF, c + 3);
    drive(1'b0, READ, 9'h01A, 16'h0);

    // Preload both ends of the address range
    c = cyc; expect_ack(1'b0, 1'b0, 16'h0, c + 2);
    drive(1'b0, WRITE, 9'h000, 16'h0F0F);
    c = cyc; expect_ack(1'b1, 1'b0, 16'h0, c + 2);
    drive(1'b1, WRITE, 9'h1FF, 16'hA55A);

    // Simultaneous reads, then a CPU-only grant, then another tie
    tie(9'h000, 16'h0F0F, 9'h1FF, 16'hA55A);
    c = cyc; expect_ack(1'b0, 1'b1, 16'hBEEF, c + 3);
    drive(1'b0, READ, 9'h01A, 16'h0);
    tie(9'h01A, 16'hBEEF, 9'h000, 16'h0F0F);

    // DMA write while CPU requests a read of the same word during ACCESS
    c = cyc;
    expect_ack(1'b1, 1'b0, 16'h0, c + 2);
    expect_ack(1'b0, 1'b1, 16'h1234, c + 6);
    fork
      drive(1'b1, WRITE, 9'h1FF, 16'h1234);
      begin
        @(posedge clk); #1;
        drive(1'b0, READ, 9'h1FF, 16'h0);
      end
    join

    // Reset during WAIT of a CPU read aborts it
    bus.cpu_cmd = READ; bus.cpu_addr = 9'h01A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_busy", int'(busy), 1);
    reset = 1'b1;
    bus.cpu_cmd = NONE;
    @(posedge clk); #1;
    check("abort_cpu_ack",   int'(bus.cpu_ack),   0);
    check("abort_cpu_rdata", int'(bus.cpu_rdata), 0);
    check("abort_busy",      int'(busy),          0);
    check("abort_ram_we",    int'(bus.ram_we),    0);
    reset = 1'b0;
    last_cpu_rdata = 16'h0;
    last_dma_rdata = 16'h0;
    last_grant = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reserved command 2'b11 is ignored
    bus.cpu_cmd = 2'b11; bus.dma_cmd = 2'b11;
    repeat (5) begin
      @(negedge clk);
      check("rsv_busy",   int'(busy),       0);
      check("rsv_ram_we", int'(bus.ram_we), 0);
    end
    @(posedge clk); #1;
    bus.cpu_cmd = NONE; bus.dma_cmd = NONE;
    repeat (3) @(posedge clk);

    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
